// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port indices, one-hot directions,
// and flit destination field extraction.
package noc_pkg;

    typedef enum logic [2:0] {
        P_N = 3'd0,
        P_S = 3'd1,
        P_E = 3'd2,
        P_W = 3'd3,
        P_L = 3'd4
    } port_e;

    localparam logic [4:0] DIR_NONE = 5'b00000;
    localparam logic [4:0] DIR_N    = 5'b00001;
    localparam logic [4:0] DIR_S    = 5'b00010;
    localparam logic [4:0] DIR_E    = 5'b00100;
    localparam logic [4:0] DIR_W    = 5'b01000;
    localparam logic [4:0] DIR_L    = 5'b10000;

    // Flits are zero-extended to 64 bits; coordinates up to 16 bits wide.
    function automatic logic [15:0] dest_x(input logic [63:0] flit,
                                           input int unsigned cw);
        logic [63:0] mask;
        mask = (64'd1 << cw) - 64'd1;
        return 16'((flit >> cw) & mask);
    endfunction

    function automatic logic [15:0] dest_y(input logic [63:0] flit,
                                           input int unsigned cw);
        logic [63:0] mask;
        mask = (64'd1 << cw) - 64'd1;
        return 16'(flit & mask);
    endfunction

endpackage

// File: rtl/xy_route_calc.sv
// Dimension-ordered XY routing: resolve X first, then Y, else eject locally.
module xy_route_calc
    import noc_pkg::*;
#(
    parameter int CW = 2
) (
    input  logic [CW-1:0] dx,
    input  logic [CW-1:0] dy,
    input  logic [CW-1:0] cx,
    input  logic [CW-1:0] cy,
    output logic [4:0]    dir
);

    always_comb begin
        dir = DIR_L;
        priority case (1'b1)
            (dx > cx): dir = DIR_E;
            (dx < cx): dir = DIR_W;
            (dy > cy): dir = DIR_N;
            (dy < cy): dir = DIR_S;
            default:   dir = DIR_L;
        endcase
    end

endmodule

// File: rtl/noc_input_port.sv
// Router input port: flit FIFO feeding a head register with a
// registered one-hot XY route request toward the switch arbiter.
module noc_input_port
    import noc_pkg::*;
#(
    parameter int FLIT_W = 32,
    parameter int CW     = 2,
    parameter int DEPTH  = 4,
    parameter int CUR_X  = 0,
    parameter int CUR_Y  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] flit_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [4:0]        req_port_addr_o,
    input  logic              grant_i,
    output logic [FLIT_W-1:0] flit_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);
    localparam logic [CW-1:0] CX = CW'(CUR_X);
    localparam logic [CW-1:0] CY = CW'(CUR_Y);

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;
    logic              head_valid;
    logic [FLIT_W-1:0] head_flit;
    logic [4:0]        head_req;

    logic              push;
    logic              pop;
    logic              load;
    logic [FLIT_W-1:0] fifo_out;
    logic [CW-1:0]     dx;
    logic [CW-1:0]     dy;
    logic [4:0]        route;

    assign ready_o  = !rst && (count < FULL);
    assign push     = valid_i && ready_o;
    assign pop      = grant_i && (head_req != DIR_NONE);
    assign load     = (!head_valid || pop) && (count != '0);
    assign fifo_out = mem[rd_ptr];
    assign dx       = CW'(dest_x(64'(fifo_out), CW));
    assign dy       = CW'(dest_y(64'(fifo_out), CW));

    assign req_port_addr_o = head_req;
    assign flit_o          = head_flit;

    // Route is computed on the FIFO output so it registers with the flit.
    xy_route_calc #(.CW(CW)) u_route (
        .dx (dx),
        .dy (dy),
        .cx (CX),
        .cy (CY),
        .dir(route)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= flit_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_flit  <= '0;
            head_req   <= DIR_NONE;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            unique case ({push, load})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (load) begin
                rd_ptr     <= rd_ptr + 1'b1;
                head_valid <= 1'b1;
                head_flit  <= fifo_out;
                head_req   <= route;
            end else if (pop) begin
                head_valid <= 1'b0;
                head_req   <= DIR_NONE;
            end
        end
    end

endmodule

// File: tb/tb_noc_input_port.sv
// Scoreboard bench for noc_input_port at router (1,1) with CW=2, DEPTH=4.
module tb_noc_input_port;

    logic        clk;
    logic        rst;
    logic [31:0] flit_i;
    logic        valid_i;
    logic        ready_o;
    logic [4:0]  req_port_addr_o;
    logic        grant_i;
    logic [31:0] flit_o;

    int checks;
    int failures;
    logic [31:0] exp_q[$];
    int rst_edges;

    noc_input_port #(
        .FLIT_W(32), .CW(2), .DEPTH(4), .CUR_X(1), .CUR_Y(1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flit_i         (flit_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .req_port_addr_o(req_port_addr_o),
        .grant_i        (grant_i),
        .flit_o         (flit_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference XY routing for router (1,1).
    function automatic logic [4:0] route_of(input logic [31:0] f);
        int dx;
        int dy;
        dx = int'(f[3:2]);
        dy = int'(f[1:0]);
        if (dx > 1) return 5'b00100;
        if (dx < 1) return 5'b01000;
        if (dy > 1) return 5'b00001;
        if (dy < 1) return 5'b00010;
        return 5'b10000;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Monitor: samples on the falling edge, pops before pushing.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            check("ready_in_reset", 64'(ready_o), 64'd0);
            if (rst_edges > 0) begin
                check("req_in_reset", 64'(req_port_addr_o), 64'd0);
                check("flit_in_reset", 64'(flit_o), 64'd0);
            end
            rst_edges++;
        end else begin
            rst_edges = 0;
            check("ready_vs_occupancy", 64'(ready_o),
                  64'(exp_q.size() < 5));
            if (exp_q.size() >= 2)
                check("head_present", 64'(req_port_addr_o != 5'b0), 64'd1);
            if (req_port_addr_o != 5'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_req: got %b expected 00000",
                             req_port_addr_o);
                end else begin
                    check("head_flit", 64'(flit_o), 64'(exp_q[0]));
                    check("head_route", 64'(req_port_addr_o),
                          64'(route_of(exp_q[0])));
                    if (grant_i) void'(exp_q.pop_front());
                end
            end
            if (valid_i && ready_o) exp_q.push_back(flit_i);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        grant_i = 1'b1;
        valid_i = 1'b0;
        while (exp_q.size() > 0 && n < 40) begin
            tick();
            n++;
        end
        grant_i = 1'b0;
        check("drain_done", 64'(exp_q.size()), 64'd0);
        tick();
    endtask

    function automatic logic [31:0] mk(input logic [1:0] x,
                                       input logic [1:0] y);
        logic [31:0] f;
        f = $urandom;
        f[3:0] = {x, y};
        return f;
    endfunction

    logic [31:0] fill[6];
    logic [31:0] f;
    logic [1:0]  rx[5];
    logic [1:0]  ry[5];
    logic [4:0]  rexp[5];

    initial begin
        checks   = 0;
        failures = 0;
        rst_edges = 0;
        rst      = 1'b1;
        valid_i  = 1'b0;
        grant_i  = 1'b0;
        flit_i   = '0;
        rx = '{2'd2, 2'd0, 2'd1, 2'd1, 2'd1};
        ry = '{2'd1, 2'd3, 2'd3, 2'd0, 2'd1};
        rexp = '{5'b00100, 5'b01000, 5'b00001, 5'b00010, 5'b10000};

        tick();
        tick();
        rst = 1'b0;
        #1;
        check("ready_after_reset", 64'(ready_o), 64'd1);
        check("req_after_reset", 64'(req_port_addr_o), 64'd0);
        check("flit_after_reset", 64'(flit_o), 64'd0);

        for (int i = 0; i < 5; i++) begin
            f = mk(rx[i], ry[i]);
            flit_i  = f;
            valid_i = 1'b1;
            tick();
            valid_i = 1'b0;
            check("route_not_yet", 64'(req_port_addr_o), 64'd0);
            tick();
            check("route_dir", 64'(req_port_addr_o), 64'(rexp[i]));
            check("route_flit", 64'(flit_o), 64'(f));
            grant_i = 1'b1;
            tick();
            grant_i = 1'b0;
            check("route_popped", 64'(req_port_addr_o), 64'd0);
        end

        for (int i = 0; i < 6; i++) begin
            fill[i] = mk(2'($urandom), 2'($urandom));
            flit_i  = fill[i];
            valid_i = 1'b1;
            tick();
            check("fill_ready", 64'(ready_o), 64'(i < 4));
            if (i > 0) check("fill_head", 64'(flit_o), 64'(fill[0]));
        end
        tick();
        check("fill_held_off", 64'(ready_o), 64'd0);
        check("fill_head_hold", 64'(flit_o), 64'(fill[0]));
        valid_i = 1'b0;
        grant_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("drain_order", 64'(flit_o), 64'(fill[i]));
            tick();
        end
        check("drained_req", 64'(req_port_addr_o), 64'd0);
        check("drained_ready", 64'(ready_o), 64'd1);
        tick();
        check("idle_grant_ignored", 64'(req_port_addr_o), 64'd0);
        check("idle_grant_ready", 64'(ready_o), 64'd1);
        grant_i = 1'b0;

        for (int i = 0; i < 3; i++) begin
            flit_i  = $urandom;
            valid_i = 1'b1;
            tick();
        end
        valid_i = 1'b0;
        tick();
        for (int i = 0; i < 12; i++) begin
            flit_i  = $urandom;
            valid_i = 1'b1;
            grant_i = 1'b1;
            tick();
            check("steady_ready", 64'(ready_o), 64'd1);
        end
        drain();

        for (int i = 0; i < 400; i++) begin
            flit_i  = $urandom;
            valid_i = 1'($urandom_range(0, 1));
            grant_i = ($urandom_range(0, 2) != 0);
            tick();
        end
        drain();

        for (int i = 0; i < 3; i++) begin
            flit_i  = $urandom;
            valid_i = 1'b1;
            tick();
        end
        valid_i = 1'b0;
        grant_i = 1'b1;
        rst     = 1'b1;
        tick();
        check("mid_reset_req", 64'(req_port_addr_o), 64'd0);
        tick();
        rst     = 1'b0;
        grant_i = 1'b0;
        #1;
        check("mid_reset_ready", 64'(ready_o), 64'd1);
        f = mk(2'd3, 2'd2);
        flit_i  = f;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        tick();
        check("post_reset_flit", 64'(flit_o), 64'(f));
        check("post_reset_route", 64'(req_port_addr_o), 64'(5'b00100));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
